// File: rtl/gamma_lut_pkg.sv
// Shared types and constants for the gamma LUT arbiter slice.
package gamma_lut_pkg;

  // ROM read-latency settings: without and with the ROM output register.
  localparam int ROM_LAT_NOREG = 1;
  localparam int ROM_LAT_OREG  = 2;

  // Largest supported requester count; sizes the index field of a tag.
  localparam int N_REQ_MAX = 8;

  // Width needed to index n requesters, never less than one bit.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int IDX_W = idx_w(N_REQ_MAX);

  // One in-flight ROM read: valid flag plus index of the requester that owns it.
  typedef struct packed {
    logic             vld;
    logic [IDX_W-1:0] idx;
  } tag_t;

endpackage

// File: rtl/gamma_lut_rr_arbiter.sv
// Combinational rotate-priority arbiter: the first set request at or above
// ptr wins, scanning upward with wrap modulo N. The pointer is held by the caller.
module rr_arbiter #(
  parameter int N     = 3,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [PTR_W-1:0] gnt_idx,
  output logic             any
);

  // Scan N positions starting at ptr and keep the first requester found.
  always_comb begin
    logic [PTR_W-1:0] pos;
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    pos     = '0;
    for (int k = 0; k < N; k++) begin
      pos = PTR_W'((int'(ptr) + k) % N);
      if (!any && req[pos]) begin
        any      = 1'b1;
        gnt[pos] = 1'b1;
        gnt_idx  = pos;
      end
    end
  end

endmodule

// File: rtl/gamma_lut_arbiter.sv
// Shares one gamma lookup ROM between N_REQ requesters: round-robin grant,
// registered ROM address, and a tag pipeline that routes each read result
// back to its requester after the fixed ROM latency.
module gamma_lut_arbiter
  import gamma_lut_pkg::*;
#(
  parameter int N_REQ   = 3,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int ROM_LAT = ROM_LAT_NOREG
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  output logic [N_REQ-1:0]        req_ready,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]       rsp_data,
  output logic [ADDR_W-1:0]       rom_addr,
  output logic                    rom_clk_en,
  output logic                    rom_rd_oce,
  input  logic [DATA_W-1:0]       rom_rd_data
);

  localparam int PTR_W = idx_w(N_REQ);
  localparam int DEPTH = ROM_LAT + 1;
  localparam logic [N_REQ-1:0] RSP_ONE = N_REQ'(1);

  // Handshake: a lookup is accepted in the cycle where req_valid[i] and
  // req_ready[i] are both high; the requester keeps req_valid[i] and its
  // address stable until then. Responses have no backpressure: rsp_data
  // belongs to requester i only in the cycle rsp_valid[i] is high.

  logic [PTR_W-1:0]  rr_ptr;
  logic [N_REQ-1:0]  gnt;
  logic [PTR_W-1:0]  gnt_idx;
  logic              gnt_any;
  logic              accept;
  logic [ADDR_W-1:0] win_addr;
  tag_t              tag_in;
  tag_t              tag_q [DEPTH];

  rr_arbiter #(
    .N     (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (gnt_any)
  );

  // Grants only while enabled and out of reset; a grant is always taken.
  assign accept    = gnt_any & en & rst_n;
  assign req_ready = accept ? gnt : '0;

  // Select the winning address and form the tag entering the pipeline.
  always_comb begin
    win_addr = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) win_addr = req_addr[i*ADDR_W +: ADDR_W];
    end
    tag_in.vld = accept;
    tag_in.idx = accept ? IDX_W'(gnt_idx) : '0;
  end

  // Pointer, ROM address and tag pipeline; tags shift every cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr   <= '0;
      rom_addr <= '0;
      for (int d = 0; d < DEPTH; d++) tag_q[d] <= '0;
    end else begin
      if (accept) begin
        rr_ptr   <= (gnt_idx == PTR_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        rom_addr <= win_addr;
      end
      tag_q[0] <= tag_in;
      for (int d = 1; d < DEPTH; d++) tag_q[d] <= tag_q[d-1];
    end
  end

  // Response routing, and ROM enable whenever a read is accepted or in flight.
  always_comb begin
    rsp_valid  = '0;
    rom_clk_en = accept;
    if (tag_q[ROM_LAT].vld && rst_n) rsp_valid = RSP_ONE << tag_q[ROM_LAT].idx;
    for (int d = 0; d < DEPTH; d++) rom_clk_en = rom_clk_en | tag_q[d].vld;
  end

  assign rsp_data = rom_rd_data;

  // Output register loads when the read in the ROM array stage is real.
  generate
    if (ROM_LAT == ROM_LAT_OREG) begin : g_oreg
      assign rom_rd_oce = tag_q[ROM_LAT-1].vld;
    end else begin : g_noreg
      assign rom_rd_oce = 1'b1;
    end
  endgenerate

endmodule

// File: tb/tb_gamma_lut_arbiter.sv
// Bench for gamma_lut_arbiter: instance A (3 requesters, ROM_LAT=2) and
// instance B (5 requesters, ROM_LAT=1), each with a behavioural ROM.
module tb_gamma_lut_arbiter;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int NA = 3;
  localparam int LA = 2;
  localparam int NB = 5;
  localparam int LB = 1;
  localparam int WA = 16 + NA + DW;
  localparam int WB = 16 + NB + DW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  logic [WA-1:0] exp_a_q[$];
  logic [WB-1:0] exp_b_q[$];

  // ---------------- DUT A ----------------
  logic             a_rst_n = 1'b0;
  logic             a_en = 1'b0;
  logic [NA-1:0]    a_req_valid = '0;
  logic [NA*AW-1:0] a_req_addr = '0;
  logic [NA-1:0]    a_req_ready, a_rsp_valid;
  logic [DW-1:0]    a_rsp_data, a_rom_rd_data, a_q1, a_q2;
  logic [AW-1:0]    a_rom_addr;
  logic             a_rom_clk_en, a_rom_rd_oce;

  gamma_lut_arbiter #(.N_REQ(NA), .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(LA)) u_a (
    .clk(clk), .rst_n(a_rst_n), .en(a_en), .req_valid(a_req_valid),
    .req_addr(a_req_addr), .req_ready(a_req_ready), .rsp_valid(a_rsp_valid),
    .rsp_data(a_rsp_data), .rom_addr(a_rom_addr), .rom_clk_en(a_rom_clk_en),
    .rom_rd_oce(a_rom_rd_oce), .rom_rd_data(a_rom_rd_data)
  );

  // ---------------- DUT B ----------------
  logic             b_rst_n = 1'b0;
  logic             b_en = 1'b0;
  logic [NB-1:0]    b_req_valid = '0;
  logic [NB*AW-1:0] b_req_addr = '0;
  logic [NB-1:0]    b_req_ready, b_rsp_valid;
  logic [DW-1:0]    b_rsp_data, b_rom_rd_data, b_q1;
  logic [AW-1:0]    b_rom_addr;
  logic             b_rom_clk_en, b_rom_rd_oce;

  gamma_lut_arbiter #(.N_REQ(NB), .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(LB)) u_b (
    .clk(clk), .rst_n(b_rst_n), .en(b_en), .req_valid(b_req_valid),
    .req_addr(b_req_addr), .req_ready(b_req_ready), .rsp_valid(b_rsp_valid),
    .rsp_data(b_rsp_data), .rom_addr(b_rom_addr), .rom_clk_en(b_rom_clk_en),
    .rom_rd_oce(b_rom_rd_oce), .rom_rd_data(b_rom_rd_data)
  );

  // ---------------- ROM models ----------------
  function automatic logic [7:0] rom_f(input logic [7:0] a);
    return (a * 8'd7) ^ 8'hA5;
  endfunction

  always @(posedge clk) begin
    if (a_rom_clk_en === 1'b1) a_q1 <= rom_f(a_rom_addr);
    if (a_rom_clk_en === 1'b1 && a_rom_rd_oce === 1'b1) a_q2 <= a_q1;
    if (b_rom_clk_en === 1'b1) b_q1 <= rom_f(b_rom_addr);
  end
  assign a_rom_rd_data = a_q2;
  assign b_rom_rd_data = b_q1;

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step_a(input logic rst, input logic en_i, input logic [NA-1:0] vld,
                        input logic [NA*AW-1:0] addr, input logic [NA-1:0] exp_gnt,
                        input bit push);
    @(negedge clk);
    a_rst_n = rst; a_en = en_i; a_req_valid = vld; a_req_addr = addr;
    #1;
    check("a_req_ready", 32'(a_req_ready), 32'(exp_gnt));
    if (push) begin
      for (int i = 0; i < NA; i++) begin
        if (exp_gnt[i]) exp_a_q.push_back({16'(cyc + 1 + LA), exp_gnt, rom_f(addr[i*AW +: AW])});
      end
    end
  endtask

  task automatic step_b(input logic rst, input logic en_i, input logic [NB-1:0] vld,
                        input logic [NB*AW-1:0] addr, input logic [NB-1:0] exp_gnt,
                        input bit push);
    @(negedge clk);
    b_rst_n = rst; b_en = en_i; b_req_valid = vld; b_req_addr = addr;
    #1;
    check("b_req_ready", 32'(b_req_ready), 32'(exp_gnt));
    n_vec++;
    if (!(u_b.rr_ptr <= 3'd4)) begin
      n_err++;
      $display("FAIL b_rr_ptr_range: got %0d expected at most 4", u_b.rr_ptr);
    end
    if (push) begin
      for (int i = 0; i < NB; i++) begin
        if (exp_gnt[i]) exp_b_q.push_back({16'(cyc + 1 + LB), exp_gnt, rom_f(addr[i*AW +: AW])});
      end
    end
  endtask

  // ---------------- scoreboard monitors ----------------
  initial begin : mon_a
    logic [WA-1:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (a_rsp_valid !== '0) begin
        if (exp_a_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL a_rsp_unexpected: got rsp_valid %0h expected none", a_rsp_valid);
        end else begin
          e = exp_a_q.pop_front();
          check("a_rsp_valid", 32'(a_rsp_valid), 32'(e[DW +: NA]));
          check("a_rsp_data", 32'(a_rsp_data), 32'(e[DW-1:0]));
          check("a_rsp_cycle", 32'(cyc), 32'(e[WA-1 -: 16]));
        end
      end
    end
  end

  initial begin : mon_b
    logic [WB-1:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (b_rsp_valid !== '0) begin
        if (exp_b_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL b_rsp_unexpected: got rsp_valid %0h expected none", b_rsp_valid);
        end else begin
          e = exp_b_q.pop_front();
          check("b_rsp_valid", 32'(b_rsp_valid), 32'(e[DW +: NB]));
          check("b_rsp_data", 32'(b_rsp_data), 32'(e[DW-1:0]));
          check("b_rsp_cycle", 32'(cyc), 32'(e[WB-1 -: 16]));
        end
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    // Reset with every requester asking: nothing granted, address cleared.
    for (int k = 0; k < 3; k++) begin
      step_a(1'b0, 1'b1, 3'b111, {8'h32, 8'h21, 8'h10}, 3'b000, 1'b0);
      check("a_rom_addr_rst", 32'(a_rom_addr), 32'h0);
      check("a_rsp_rst", 32'(a_rsp_valid), 32'h0);
    end

    // Release: grants rotate 0,1,2,0,1,2; addresses change after each accept.
    step_a(1'b1, 1'b1, 3'b111, {8'h32, 8'h21, 8'h10}, 3'b001, 1'b1);
    step_a(1'b1, 1'b1, 3'b111, {8'h32, 8'h21, 8'h13}, 3'b010, 1'b1);
    step_a(1'b1, 1'b1, 3'b111, {8'h32, 8'h24, 8'h13}, 3'b100, 1'b1);
    step_a(1'b1, 1'b1, 3'b111, {8'h35, 8'h24, 8'h13}, 3'b001, 1'b1);
    step_a(1'b1, 1'b1, 3'b111, {8'h35, 8'h24, 8'h16}, 3'b010, 1'b1);
    step_a(1'b1, 1'b1, 3'b111, {8'h35, 8'h27, 8'h16}, 3'b100, 1'b1);

    // Two reads, then en low for 4 cycles: both drain, no new grants.
    step_a(1'b1, 1'b1, 3'b001, {8'h00, 8'h00, 8'h40}, 3'b001, 1'b1);
    step_a(1'b1, 1'b1, 3'b010, {8'h00, 8'h41, 8'h00}, 3'b010, 1'b1);
    step_a(1'b1, 1'b0, 3'b111, {8'h52, 8'h51, 8'h50}, 3'b000, 1'b0);
    check("a_clk_en_busy", 32'(a_rom_clk_en), 32'h1);
    check("a_oce_busy", 32'(a_rom_rd_oce), 32'h1);
    step_a(1'b1, 1'b0, 3'b111, {8'h52, 8'h51, 8'h50}, 3'b000, 1'b0);
    step_a(1'b1, 1'b0, 3'b111, {8'h52, 8'h51, 8'h50}, 3'b000, 1'b0);
    step_a(1'b1, 1'b0, 3'b111, {8'h52, 8'h51, 8'h50}, 3'b000, 1'b0);
    check("a_clk_en_drained", 32'(a_rom_clk_en), 32'h0);
    check("a_oce_drained", 32'(a_rom_rd_oce), 32'h0);

    // Accept to requester 2, then reset next cycle: that read is discarded.
    step_a(1'b1, 1'b1, 3'b100, {8'h60, 8'h00, 8'h00}, 3'b100, 1'b0);
    step_a(1'b0, 1'b1, 3'b111, {8'h60, 8'h00, 8'h00}, 3'b000, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step_a(1'b1, 1'b0, 3'b000, '0, 3'b000, 1'b0);
      check("a_clk_en_after_rst", 32'(a_rom_clk_en), 32'h0);
      check("a_rsp_after_rst", 32'(a_rsp_valid), 32'h0);
    end
    // Pointer restarted at 0: requester 1 wins over 2.
    step_a(1'b1, 1'b1, 3'b110, {8'h62, 8'h61, 8'h00}, 3'b010, 1'b1);
    for (int k = 0; k < 4; k++) step_a(1'b1, 1'b1, 3'b000, '0, 3'b000, 1'b0);

    // Instance B: reset, then single requester 1 back-to-back at ROM_LAT=1.
    step_b(1'b0, 1'b1, 5'b00000, '0, 5'b00000, 1'b0);
    step_b(1'b0, 1'b1, 5'b00000, '0, 5'b00000, 1'b0);
    check("b_oce_const", 32'(b_rom_rd_oce), 32'h1);
    step_b(1'b1, 1'b1, 5'b00010, 40'h00_00_00_10_00, 5'b00010, 1'b1);
    step_b(1'b1, 1'b1, 5'b00010, 40'h00_00_00_11_00, 5'b00010, 1'b1);
    step_b(1'b1, 1'b1, 5'b00010, 40'h00_00_00_12_00, 5'b00010, 1'b1);

    // Requesters 4 and 0 only: pointer at 2 so 4 wins first, then alternate.
    step_b(1'b1, 1'b1, 5'b10001, 40'h84_00_00_00_80, 5'b10000, 1'b1);
    step_b(1'b1, 1'b1, 5'b10001, 40'h85_00_00_00_80, 5'b00001, 1'b1);
    step_b(1'b1, 1'b1, 5'b10001, 40'h85_00_00_00_81, 5'b10000, 1'b1);
    step_b(1'b1, 1'b1, 5'b10001, 40'h86_00_00_00_81, 5'b00001, 1'b1);
    for (int k = 0; k < 4; k++) step_b(1'b1, 1'b1, 5'b00000, '0, 5'b00000, 1'b0);
    check("b_clk_en_idle", 32'(b_rom_clk_en), 32'h0);

    // Every expected response must have been seen.
    @(negedge clk);
    #3;
    check("a_queue_empty", 32'(exp_a_q.size()), 32'h0);
    check("b_queue_empty", 32'(exp_b_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
